// File: rtl/sim_pkg.sv
// rtl/sim_pkg.sv - shared widths, FSM states and saturation helpers for the axis simulator
package sim_pkg;

  // Integer-part widths; each user adds its own PRECISION fractional bits.
  localparam int IN_INT  = 16;
  localparam int ACC_INT = 18;
  localparam int VEL_INT = 24;
  localparam int POS_INT = 26;
  localparam int STEP_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_VEL,
    S_POS,
    S_WR,
    S_DONE
  } state_t;

  typedef logic signed [63:0] wide_t;

  function automatic wide_t saturate(input wide_t v, input wide_t lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Compares on whole steps, so a fractional overshoot inside the end step is kept.
  function automatic wide_t clamp_steps(input wide_t p, input wide_t lo, input wide_t hi,
                                        input int prec);
    if ((p >>> prec) > hi) return hi <<< prec;
    if ((p >>> prec) < lo) return lo <<< prec;
    return p;
  endfunction

endpackage

// File: rtl/sim_tick_gen.sv
// rtl/sim_tick_gen.sv - free-running simulation tick or pass-through of an external strobe
module sim_tick_gen #(
  parameter int SIM_PERIOD = 500_000,
  parameter bit EXT_TICK   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic ext_tick,
  output logic tick
);

  localparam int CW = (SIM_PERIOD > 1) ? $clog2(SIM_PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(SIM_PERIOD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = EXT_TICK ? ext_tick : wrap;

endmodule

// File: rtl/multi_axis_simulator.sv
// rtl/multi_axis_simulator.sv - time-multiplexed acc/vel/pos integrator for CHANNELS stepper axes
module multi_axis_simulator
  import sim_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int PRECISION  = 16,
  parameter int SIM_PERIOD = 500_000,
  parameter bit EXT_TICK   = 1'b0,
  parameter int DAMP_SHIFT = 0,
  parameter int VEL_MAX    = 32767,
  parameter int POS_MIN    = -32768,
  parameter int POS_MAX    = 32767
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  ext_tick,
  input  logic [CHANNELS*(16+PRECISION)-1:0]    alavanca1,
  input  logic [CHANNELS*(16+PRECISION)-1:0]    alavanca2,
  input  logic [16+PRECISION-1:0]               gravity,
  input  logic [CHANNELS-1:0]                   zero_req,
  output logic [CHANNELS*16-1:0]                delta_steps,
  output logic [CHANNELS*16-1:0]                current_pos,
  output logic [CHANNELS-1:0]                   limit_hit,
  output logic                                  busy,
  output logic                                  update_done,
  output logic                                  tick_overrun
);

  localparam int IN_W  = IN_INT + PRECISION;
  localparam int ACC_W = ACC_INT + PRECISION;
  localparam int VEL_W = VEL_INT + PRECISION;
  localparam int POS_W = POS_INT + PRECISION;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam wide_t VEL_LIM = wide_t'(VEL_MAX) <<< PRECISION;

  state_t            state, nstate;
  logic              tick;
  logic [CH_W-1:0]   ch;
  logic              last_ch;

  logic [CHANNELS*IN_W-1:0] al1_s, al2_s;
  logic [IN_W-1:0]          grav_s;
  logic [CHANNELS-1:0]      zero_s;

  logic signed [ACC_W-1:0]  acc_r;
  logic signed [VEL_W-1:0]  vel_r;
  logic signed [POS_W-1:0]  pos_r;
  logic                     lim_r;

  logic signed [VEL_W-1:0]  vel_mem [CHANNELS];
  logic signed [POS_W-1:0]  pos_mem [CHANNELS];
  logic signed [STEP_W-1:0] cur_mem [CHANNELS];
  logic signed [STEP_W-1:0] dlt_mem [CHANNELS];

  logic signed [IN_W-1:0]   a1, a2, g;
  logic signed [STEP_W-1:0] new_pos;
  wide_t acc_sum, vel_sum, vel_sat, pos_sum, pos_clamped;

  sim_tick_gen #(
    .SIM_PERIOD (SIM_PERIOD),
    .EXT_TICK   (EXT_TICK)
  ) u_tick (
    .clock    (clock),
    .reset    (reset),
    .ext_tick (ext_tick),
    .tick     (tick)
  );

  assign last_ch = (ch == CH_W'(CHANNELS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (tick) nstate = S_ACC;
      S_ACC:   nstate = S_VEL;
      S_VEL:   nstate = S_POS;
      S_POS:   nstate = S_WR;
      S_WR:    nstate = last_ch ? S_DONE : S_ACC;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    update_done = (state == S_DONE);
  end

  // Shared datapath, one stage per FSM state for the channel selected by ch.
  always_comb begin
    a1          = al1_s[int'(ch)*IN_W +: IN_W];
    a2          = al2_s[int'(ch)*IN_W +: IN_W];
    g           = grav_s;
    acc_sum     = wide_t'(a1) + wide_t'(a2) + wide_t'(g);
    vel_sum     = wide_t'(vel_mem[ch]) + wide_t'(acc_r)
                - ((DAMP_SHIFT != 0) ? (wide_t'(vel_mem[ch]) >>> DAMP_SHIFT) : wide_t'(0));
    vel_sat     = saturate(vel_sum, VEL_LIM);
    pos_sum     = wide_t'(pos_mem[ch]) + wide_t'(vel_r);
    pos_clamped = clamp_steps(pos_sum, wide_t'(POS_MIN), wide_t'(POS_MAX), PRECISION);
    new_pos     = pos_r[PRECISION +: STEP_W];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch           <= '0;
      al1_s        <= '0;
      al2_s        <= '0;
      grav_s       <= '0;
      zero_s       <= '0;
      acc_r        <= '0;
      vel_r        <= '0;
      pos_r        <= '0;
      lim_r        <= 1'b0;
      limit_hit    <= '0;
      tick_overrun <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        vel_mem[k] <= '0;
        pos_mem[k] <= '0;
        cur_mem[k] <= '0;
        dlt_mem[k] <= '0;
      end
    end else begin
      if (tick && state == S_IDLE) begin
        al1_s  <= alavanca1;
        al2_s  <= alavanca2;
        grav_s <= gravity;
        zero_s <= zero_req;
        ch     <= '0;
      end
      if (tick && state != S_IDLE) begin
        tick_overrun <= 1'b1;
      end
      case (state)
        S_ACC: acc_r <= ACC_W'(acc_sum);
        S_VEL: vel_r <= VEL_W'(vel_sat);
        S_POS: begin
          pos_r <= POS_W'(pos_clamped);
          lim_r <= (pos_clamped != pos_sum);
          if (pos_clamped != pos_sum) vel_r <= '0;
        end
        S_WR: begin
          if (zero_s[ch]) begin
            vel_mem[ch]   <= '0;
            pos_mem[ch]   <= '0;
            cur_mem[ch]   <= '0;
            dlt_mem[ch]   <= -cur_mem[ch];
            limit_hit[ch] <= 1'b0;
          end else begin
            vel_mem[ch] <= vel_r;
            pos_mem[ch] <= pos_r;
            cur_mem[ch] <= new_pos;
            dlt_mem[ch] <= new_pos - cur_mem[ch];
            if (lim_r) limit_hit[ch] <= 1'b1;
          end
          if (!last_ch) ch <= ch + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_out
    assign current_pos[k*STEP_W +: STEP_W] = cur_mem[k];
    assign delta_steps[k*STEP_W +: STEP_W] = dlt_mem[k];
  end

endmodule

// File: tb/tb_multi_axis_simulator.sv
// tb/tb_multi_axis_simulator.sv - self-checking bench for multi_axis_simulator
module tb_multi_axis_simulator;

  logic        clk;
  logic        a_rst, b_rst, a_ext, b_ext;
  logic [63:0] a_al1, a_al2, b_al1, b_al2;
  logic [31:0] a_gr, b_gr;
  logic [1:0]  a_zr, b_zr;
  logic [31:0] a_dlt, a_pos, b_dlt, b_pos;
  logic [1:0]  a_lim, b_lim;
  logic        a_busy, a_done, a_ovr, b_busy, b_done, b_ovr;

  int checks = 0;
  int errors = 0;

  // Reference state per instance (0 = internal tick, 1 = external tick with damping).
  longint m_vel [2][2];
  longint m_pos [2][2];
  int     m_cur [2][2];
  int     m_dlt [2][2];
  bit     m_lim [2][2];
  int     p_damp [2] = '{0, 4};
  longint p_vmax [2] = '{20, 32767};
  longint p_pmin [2] = '{-40, -32768};
  longint p_pmax [2] = '{100, 32767};

  multi_axis_simulator #(
    .CHANNELS(2), .PRECISION(16), .SIM_PERIOD(64), .EXT_TICK(1'b0), .DAMP_SHIFT(0),
    .VEL_MAX(20), .POS_MIN(-40), .POS_MAX(100)
  ) dut_a (
    .clock(clk), .reset(a_rst), .ext_tick(a_ext), .alavanca1(a_al1), .alavanca2(a_al2),
    .gravity(a_gr), .zero_req(a_zr), .delta_steps(a_dlt), .current_pos(a_pos),
    .limit_hit(a_lim), .busy(a_busy), .update_done(a_done), .tick_overrun(a_ovr)
  );

  multi_axis_simulator #(
    .CHANNELS(2), .PRECISION(16), .SIM_PERIOD(64), .EXT_TICK(1'b1), .DAMP_SHIFT(4),
    .VEL_MAX(32767), .POS_MIN(-32768), .POS_MAX(32767)
  ) dut_b (
    .clock(clk), .reset(b_rst), .ext_tick(b_ext), .alavanca1(b_al1), .alavanca2(b_al2),
    .gravity(b_gr), .zero_req(b_zr), .delta_steps(b_dlt), .current_pos(b_pos),
    .limit_hit(b_lim), .busy(b_busy), .update_done(b_done), .tick_overrun(b_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] x);
    return longint'(signed'(x));
  endfunction

  task automatic model_reset(input int d);
    for (int c = 0; c < 2; c++) begin
      m_vel[d][c] = 0; m_pos[d][c] = 0; m_cur[d][c] = 0; m_dlt[d][c] = 0; m_lim[d][c] = 0;
    end
  endtask

  task automatic model_tick(input int d, input logic [63:0] l1, input logic [63:0] l2,
                            input logic [31:0] gr, input logic [1:0] zr);
    longint acc, v, p, vl;
    int np;
    for (int c = 0; c < 2; c++) begin
      acc = sx(l1[c*32 +: 32]) + sx(l2[c*32 +: 32]) + sx(gr);
      if (zr[c]) begin
        m_dlt[d][c] = -m_cur[d][c];
        m_cur[d][c] = 0; m_vel[d][c] = 0; m_pos[d][c] = 0; m_lim[d][c] = 0;
      end else begin
        v = m_vel[d][c] + acc;
        if (p_damp[d] != 0) v = v - (m_vel[d][c] >>> p_damp[d]);
        vl = p_vmax[d] * 65536;
        if (v > vl) v = vl;
        else if (v < -vl) v = -vl;
        p = m_pos[d][c] + v;
        if ((p >>> 16) > p_pmax[d]) begin
          p = p_pmax[d] * 65536; v = 0; m_lim[d][c] = 1;
        end else if ((p >>> 16) < p_pmin[d]) begin
          p = p_pmin[d] * 65536; v = 0; m_lim[d][c] = 1;
        end
        np = int'(p >>> 16);
        m_dlt[d][c] = np - m_cur[d][c];
        m_cur[d][c] = np; m_vel[d][c] = v; m_pos[d][c] = p;
      end
    end
  endtask

  task automatic compare(input int d, input string tag);
    logic [31:0] ep, ed;
    logic [1:0]  el;
    ep = {16'(m_cur[d][1]), 16'(m_cur[d][0])};
    ed = {16'(m_dlt[d][1]), 16'(m_dlt[d][0])};
    el = {m_lim[d][1], m_lim[d][0]};
    check({tag, "_pos"}, (d == 0) ? 64'(a_pos) : 64'(b_pos), 64'(ep));
    check({tag, "_dlt"}, (d == 0) ? 64'(a_dlt) : 64'(b_dlt), 64'(ed));
    check({tag, "_lim"}, (d == 0) ? 64'(a_lim) : 64'(b_lim), 64'(el));
  endtask

  task automatic wait_done(input int d);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (((d == 0) ? a_done : b_done) === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL done_timeout dut=%0d observed=0 expected=1", d);
    end
  endtask

  // Inputs are set right after the previous update, well ahead of the next internal tick.
  task automatic a_tick(input logic [63:0] l1, input logic [63:0] l2, input logic [31:0] gr,
                        input logic [1:0] zr, input string tag);
    a_al1 = l1; a_al2 = l2; a_gr = gr; a_zr = zr;
    wait_done(0);
    model_tick(0, l1, l2, gr, zr);
    compare(0, tag);
  endtask

  task automatic b_tick(input logic [63:0] l1, input logic [63:0] l2, input logic [31:0] gr,
                        input logic [1:0] zr, input string tag);
    @(negedge clk);
    b_al1 = l1; b_al2 = l2; b_gr = gr; b_zr = zr; b_ext = 1'b1;
    @(negedge clk);
    b_ext = 1'b0;
    wait_done(1);
    model_tick(1, l1, l2, gr, zr);
    compare(1, tag);
  endtask

  function automatic logic [31:0] rnd_acc();
    return 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
  endfunction

  initial begin
    int first;
    bit saw;
    logic signed [15:0] d0;
    logic [63:0] r1, r2;
    logic [31:0] rg;
    logic [1:0]  rz;

    a_rst = 1'b1; b_rst = 1'b1; a_ext = 1'b0; b_ext = 1'b0;
    a_al1 = '0; a_al2 = '0; a_gr = '0; a_zr = '0;
    b_al1 = '0; b_al2 = '0; b_gr = '0; b_zr = '0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    check("rst_a_pos", a_pos, 0);   check("rst_a_dlt", a_dlt, 0);
    check("rst_a_lim", a_lim, 0);   check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0); check("rst_a_ovr", a_ovr, 0);
    check("rst_b_pos", b_pos, 0);   check("rst_b_ovr", b_ovr, 0);
    b_rst = 1'b0;

    // External tick pulses three clocks apart: second one is an overrun.
    @(negedge clk);
    b_gr = 32'h0001_0000; b_ext = 1'b1;
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      b_ext = (k == 3);
      if (k == 1) check("busy_set", b_busy, 1);
      if (b_done === 1'b1 && first == 0) first = k;
    end
    check("ext_latency", first, 9);
    check("tick_overrun", b_ovr, 1);
    model_tick(1, '0, '0, 32'h0001_0000, 2'b00);
    compare(1, "overrun");

    // Reset three clocks into an update sequence.
    @(negedge clk); b_ext = 1'b1;
    @(negedge clk); b_ext = 1'b0;
    @(negedge clk);
    @(negedge clk);
    b_rst = 1'b1;
    #1;
    check("midrst_busy", b_busy, 0); check("midrst_pos", b_pos, 0);
    check("midrst_dlt", b_dlt, 0);   check("midrst_lim", b_lim, 0);
    check("midrst_ovr", b_ovr, 0);
    @(negedge clk);
    b_rst = 1'b0;
    saw = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (b_done === 1'b1) saw = 1;
    end
    check("midrst_no_done", saw, 0);
    model_reset(1);
    b_tick('0, '0, 32'h0001_0000, 2'b00, "after_rst");
    check("after_rst_pos", b_pos, {16'd1, 16'd1});

    // Damped constant thrust on channel 0 only; it eventually runs into the default end-stop.
    @(negedge clk); b_rst = 1'b1;
    @(negedge clk); b_rst = 1'b0;
    model_reset(1);
    for (int k = 1; k <= 200; k++) begin
      b_tick({32'h0, 32'h0010_0000}, '0, '0, 2'b00, "damp");
      if (k == 120) begin
        d0 = b_dlt[15:0];
        check("damp_settle", 64'(d0 >= 16'sd255 && d0 <= 16'sd256), 1);
        check("damp_ch1_idle", b_pos[31:16], 0);
      end
    end

    // Internal tick: constant gravity ramp into POS_MAX.
    @(negedge clk);
    a_rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      a_tick('0, '0, 32'h0001_0000, 2'b00, "ramp");
      if (k <= 4) begin
        check("ramp_pos_const", a_pos, {2{16'(k * (k + 1) / 2)}});
        check("ramp_dlt_const", a_dlt, {2{16'(k)}});
      end
      if (k == 14) begin
        check("limit_pos", a_pos, {2{16'd100}});
        check("limit_hit", a_lim, 2'b11);
      end
    end
    check("reclamp_dlt", a_dlt, 0);
    for (int k = 0; k < 4; k++) a_tick('0, '0, 32'hFFFF_0000, 2'b00, "fall");
    a_tick('0, '0, 32'hFFFF_0000, 2'b01, "zero");
    check("zero_pos0", a_pos[15:0], 0);
    check("zero_dlt0", a_dlt[15:0], 16'hFFA6);
    check("zero_pos1", a_pos[31:16], 16'd85);
    check("zero_lim", a_lim, 2'b10);
    check("int_no_ovr", a_ovr, 0);

    // Random accelerations with occasional zero requests; saturation and both end-stops.
    for (int k = 0; k < 30; k++) begin
      r1 = {rnd_acc(), rnd_acc()};
      r2 = {rnd_acc(), rnd_acc()};
      rg = rnd_acc();
      rz = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      a_tick(r1, r2, rg, rz, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
